// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Main control FSM for a multicycle RV32I subset datapath (lw, sw, R-type,
// beq). Sequences fetch/decode/execute/memory/writeback, drives every
// datapath enable plus aluOp, stalls on memReady, and counts retired
// instructions. Control outputs are decoded from the state register only;
// the FETCH write strobes are qualified by memReady so the IR and PC update
// exactly once, on the cycle the fetch completes.
// ---------------------------------------------------------------------------
module multicycle_control #(
    parameter int CNT_W        = 32,
    parameter int FETCH_PC_INC = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             memReady,
    output logic             pcWrite,
    output logic             pcWriteCond,
    output logic             irWrite,
    output logic             memRead,
    output logic             memWrite,
    output logic             iOrD,
    output logic             regWrite,
    output logic             memToReg,
    output logic             aluSrcA,
    output logic [1:0]       aluSrcB,
    output logic [1:0]       aluOp,
    output logic             pcSource,
    output logic [3:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    // State encoding (also exported on the debug port).
    localparam logic [3:0] FETCH     = 4'd0;
    localparam logic [3:0] DECODE    = 4'd1;
    localparam logic [3:0] MEM_ADDR  = 4'd2;
    localparam logic [3:0] MEM_READ  = 4'd3;
    localparam logic [3:0] MEM_WB    = 4'd4;
    localparam logic [3:0] MEM_WRITE = 4'd5;
    localparam logic [3:0] EXECUTE   = 4'd6;
    localparam logic [3:0] ALU_WB    = 4'd7;
    localparam logic [3:0] BRANCH    = 4'd8;

    // Supported opcodes.
    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BEQ    = 7'b1100011;

    // aluSrcB / aluOp codes.
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic PC_INC_EN = (FETCH_PC_INC != 0);

    logic [3:0]       r_state;
    logic [3:0]       w_next_state;
    logic             r_illegal;
    logic             w_illegal_next;
    logic             w_retire;
    logic [CNT_W-1:0] r_retired;

    // Next-state logic; opcode is only looked at in DECODE and MEM_ADDR.
    always_comb begin
        // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
        w_next_state   = FETCH;
        w_illegal_next = 1'b0;
        case (r_state)
            FETCH:     w_next_state = memReady ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_next_state = MEM_ADDR;
                    OP_RTYPE:     w_next_state = EXECUTE;
                    OP_BEQ:       w_next_state = BRANCH;
                    default: begin
                        w_next_state   = FETCH;
                        w_illegal_next = 1'b1;
                    end
                endcase
            end
            MEM_ADDR:  w_next_state = (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
            MEM_READ:  w_next_state = memReady ? MEM_WB : MEM_READ;
            MEM_WB:    w_next_state = FETCH;
            MEM_WRITE: w_next_state = memReady ? FETCH : MEM_WRITE;
            EXECUTE:   w_next_state = ALU_WB;
            ALU_WB:    w_next_state = FETCH;
            BRANCH:    w_next_state = FETCH;
            default:   w_next_state = FETCH;
        endcase
    end

    // An instruction retires on the edge that returns the FSM to FETCH
    // from a completing state (illegal opcodes never get here).
    always_comb begin
        w_retire = 1'b0;
        case (r_state)
            MEM_WB, ALU_WB, BRANCH: w_retire = 1'b1;
            MEM_WRITE:              w_retire = memReady;
            default:                w_retire = 1'b0;
        endcase
    end

    // State register, illegal pulse and retired counter; reset wins over all.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_state   <= FETCH;
            r_illegal <= 1'b0;
            r_retired <= '0;
        end else begin
            r_state   <= w_next_state;
            r_illegal <= w_illegal_next;
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    // Moore output decode: anything not listed for a state stays 0.
    always_comb begin
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        irWrite     = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        iOrD        = 1'b0;
        regWrite    = 1'b0;
        memToReg    = 1'b0;
        aluSrcA     = 1'b0;
        aluSrcB     = SRCB_RS2;
        aluOp       = ALU_ADD;
        pcSource    = 1'b0;
        case (r_state)
            FETCH: begin
                memRead = 1'b1;
                irWrite = memReady;
                aluSrcB = SRCB_FOUR;
                pcWrite = memReady & PC_INC_EN;
            end
            DECODE: begin
                aluSrcB = SRCB_IMM;
            end
            MEM_ADDR: begin
                aluSrcA = 1'b1;
                aluSrcB = SRCB_IMM;
            end
            MEM_READ: begin
                memRead = 1'b1;
                iOrD    = 1'b1;
            end
            MEM_WB: begin
                regWrite = 1'b1;
                memToReg = 1'b1;
            end
            MEM_WRITE: begin
                memWrite = 1'b1;
                iOrD     = 1'b1;
            end
            EXECUTE: begin
                aluSrcA = 1'b1;
                aluOp   = ALU_FUNCT;
            end
            ALU_WB: begin
                regWrite = 1'b1;
            end
            BRANCH: begin
                aluSrcA     = 1'b1;
                aluOp       = ALU_SUB;
                pcWriteCond = 1'b1;
                pcSource    = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign state   = r_state;
    assign illegal = r_illegal;
    assign retired = r_retired;

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
// Directed test of the multicycle control FSM with hand-computed expected
// values. Inputs change at the falling edge; outputs are checked 1 ns later.
// A second instance with a 4-bit counter exercises counter wrap.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic       memReady;
    logic       pcWrite, pcWriteCond, irWrite, memRead, memWrite, iOrD;
    logic       regWrite, memToReg, aluSrcA, pcSource, illegal;
    logic [1:0] aluSrcB, aluOp;
    logic [3:0] state;
    logic [31:0] retired;

    logic       reset4;
    logic [6:0] opcode4;
    logic       memReady4;
    logic       pcWrite4, pcWriteCond4, irWrite4, memRead4, memWrite4, iOrD4;
    logic       regWrite4, memToReg4, aluSrcA4, pcSource4, illegal4;
    logic [1:0] aluSrcB4, aluOp4;
    logic [3:0] state4;
    logic [3:0] retired4;

    int n_total = 0;
    int n_bad   = 0;

    localparam logic [6:0] LW = 7'b0000011;
    localparam logic [6:0] SW = 7'b0100011;
    localparam logic [6:0] RT = 7'b0110011;
    localparam logic [6:0] BQ = 7'b1100011;
    localparam logic [6:0] XX = 7'b1111111;

    always #5 clk = ~clk;

    multicycle_control #(.CNT_W(32), .FETCH_PC_INC(1)) u_dut (
        .clk(clk), .reset(reset), .opcode(opcode), .memReady(memReady),
        .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .irWrite(irWrite),
        .memRead(memRead), .memWrite(memWrite), .iOrD(iOrD),
        .regWrite(regWrite), .memToReg(memToReg), .aluSrcA(aluSrcA),
        .aluSrcB(aluSrcB), .aluOp(aluOp), .pcSource(pcSource),
        .state(state), .illegal(illegal), .retired(retired)
    );

    multicycle_control #(.CNT_W(4), .FETCH_PC_INC(1)) u_dut4 (
        .clk(clk), .reset(reset4), .opcode(opcode4), .memReady(memReady4),
        .pcWrite(pcWrite4), .pcWriteCond(pcWriteCond4), .irWrite(irWrite4),
        .memRead(memRead4), .memWrite(memWrite4), .iOrD(iOrD4),
        .regWrite(regWrite4), .memToReg(memToReg4), .aluSrcA(aluSrcA4),
        .aluSrcB(aluSrcB4), .aluOp(aluOp4), .pcSource(pcSource4),
        .state(state4), .illegal(illegal4), .retired(retired4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, then settle.
    task automatic cyc(input logic [6:0] op, input logic rdy);
        @(negedge clk);
        opcode   = op;
        memReady = rdy;
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; memReady = 1'b1; opcode = RT;
        reset4 = 1'b1; memReady4 = 1'b1; opcode4 = BQ;

        // Reset with memReady=1 for two edges, then release in FETCH.
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_state",    state,    0);
        check("rst_retired",  retired,  0);
        check("rst_illegal",  illegal,  0);
        check("rst_memRead",  memRead,  1);
        check("rst_aluSrcB",  aluSrcB,  1);
        check("rst_pcWrite",  pcWrite,  1);
        check("rst_irWrite",  irWrite,  1);
        check("rst_memWrite", memWrite, 0);
        check("rst_regWrite", regWrite, 0);
        check("rst_iOrD",     iOrD,     0);
        check("rst_aluOp",    aluOp,    0);

        // R-type: 0,1,6,7,0
        cyc(RT, 1);
        check("rt_dec_state",   state,   1);
        check("rt_dec_aluSrcB", aluSrcB, 2);
        check("rt_dec_memRead", memRead, 0);
        cyc(RT, 1);
        check("rt_ex_state",    state,    6);
        check("rt_ex_aluOp",    aluOp,    2);
        check("rt_ex_aluSrcA",  aluSrcA,  1);
        check("rt_ex_aluSrcB",  aluSrcB,  0);
        check("rt_ex_regWrite", regWrite, 0);
        cyc(RT, 1);
        check("rt_wb_state",    state,    7);
        check("rt_wb_regWrite", regWrite, 1);
        check("rt_wb_memToReg", memToReg, 0);
        check("rt_wb_aluOp",    aluOp,    0);
        check("rt_wb_retired",  retired,  0);
        cyc(LW, 1);
        check("rt_end_state",   state,   0);
        check("rt_end_retired", retired, 1);

        // lw with two stall cycles in MEM_READ: 0,1,2,3,3,3,4,0
        cyc(LW, 1);
        check("lw_dec_state", state, 1);
        cyc(LW, 1);
        check("lw_adr_state",   state,   2);
        check("lw_adr_aluSrcA", aluSrcA, 1);
        check("lw_adr_aluSrcB", aluSrcB, 2);
        cyc(XX, 0);
        check("lw_rd0_state",   state,   3);
        check("lw_rd0_memRead", memRead, 1);
        check("lw_rd0_iOrD",    iOrD,    1);
        check("lw_rd0_irWrite", irWrite, 0);
        cyc(XX, 0);
        check("lw_rd1_state", state, 3);
        cyc(XX, 1);
        check("lw_rd2_state", state, 3);
        cyc(XX, 1);
        check("lw_wb_state",    state,    4);
        check("lw_wb_regWrite", regWrite, 1);
        check("lw_wb_memToReg", memToReg, 1);
        check("lw_wb_illegal",  illegal,  0);
        cyc(SW, 1);
        check("lw_end_state",   state,   0);
        check("lw_end_retired", retired, 2);

        // sw then beq
        cyc(SW, 1);
        check("sw_dec_state",    state,    1);
        check("sw_dec_memWrite", memWrite, 0);
        cyc(SW, 1);
        check("sw_adr_state",    state,    2);
        check("sw_adr_memWrite", memWrite, 0);
        cyc(BQ, 1);
        check("sw_wr_state",    state,    5);
        check("sw_wr_memWrite", memWrite, 1);
        check("sw_wr_iOrD",     iOrD,     1);
        check("sw_wr_memRead",  memRead,  0);
        cyc(BQ, 1);
        check("beq_f_state",    state,    0);
        check("beq_f_memWrite", memWrite, 0);
        check("beq_f_retired",  retired,  3);
        cyc(BQ, 1);
        check("beq_dec_state", state, 1);
        cyc(BQ, 1);
        check("beq_br_state",       state,       8);
        check("beq_br_aluOp",       aluOp,       1);
        check("beq_br_pcWriteCond", pcWriteCond, 1);
        check("beq_br_pcSource",    pcSource,    1);
        check("beq_br_aluSrcA",     aluSrcA,     1);
        check("beq_br_memWrite",    memWrite,    0);
        check("beq_br_pcWrite",     pcWrite,     0);
        cyc(XX, 1);
        check("beq_end_state",   state,   0);
        check("beq_end_retired", retired, 4);

        // Illegal opcode: DECODE -> FETCH, one-cycle illegal pulse
        cyc(XX, 1);
        check("ill_dec_state",   state,   1);
        check("ill_dec_illegal", illegal, 0);
        cyc(SW, 1);
        check("ill_f_state",   state,   0);
        check("ill_f_illegal", illegal, 1);
        check("ill_f_retired", retired, 4);
        cyc(SW, 1);
        check("ill_dec2_state",   state,   1);
        check("ill_dec2_illegal", illegal, 0);

        // Reset during a MEM_WRITE stall, asserted together with memReady=1
        cyc(SW, 1);
        check("rw_adr_state", state, 2);
        cyc(SW, 0);
        check("rw_st0_state",    state,    5);
        check("rw_st0_memWrite", memWrite, 1);
        @(negedge clk);
        reset = 1'b1; memReady = 1'b1;
        #1;
        check("rw_st1_state",   state,   5);
        check("rw_st1_retired", retired, 4);
        @(negedge clk);
        reset = 1'b0; memReady = 1'b0;
        #1;
        check("rw_post_state",    state,    0);
        check("rw_post_memWrite", memWrite, 0);
        check("rw_post_retired",  retired,  0);
        check("rw_post_memRead",  memRead,  1);
        check("rw_post_irWrite",  irWrite,  0);
        check("rw_post_pcWrite",  pcWrite,  0);
        cyc(RT, 1);
        check("rw_stall_state", state, 0);
        cyc(RT, 1);
        check("rw_go_state", state, 1);

        // 4-bit counter wrap: 15 beqs reach 15, the 16th wraps to 0
        @(negedge clk);
        reset4 = 1'b0;
        #1;
        check("w4_rst_state",   state4,   0);
        check("w4_rst_retired", retired4, 0);
        repeat (45) @(negedge clk);
        #1;
        check("w4_15_state",   state4,   0);
        check("w4_15_retired", retired4, 15);
        repeat (2) @(negedge clk);
        #1;
        check("w4_br_state",   state4,   8);
        check("w4_br_retired", retired4, 15);
        @(negedge clk);
        #1;
        check("w4_wrap_state",   state4,   0);
        check("w4_wrap_retired", retired4, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
